// File: rtl/tdm_converter.sv
// TDM timing converter: turns a 4.096 MHz c4 clock and 8 kHz active-low frame
// pulse into a timeslot window enable and burst bit clock (TX, plus RX one cycle later).
module tdm_converter #(
   parameter int unsigned TS_A = 0,
   parameter int unsigned TS_B = 16
) (
   input  logic c4,
   input  logic rst_n,
   input  logic f0,
   input  logic select,
   output logic clk_en_tx,
   output logic clk_en_rx,
   output logic clk_tx,
   output logic clk_rx
);

   localparam logic [4:0] SLOT_A = TS_A[4:0];
   localparam logic [4:0] SLOT_B = TS_B[4:0];

   logic       f0_q;
   logic [8:0] cnt_q, cnt_d;
   logic       synced_q, synced_d;
   logic       sel_q, sel_d;
   logic       en_tx_q, en_tx_d;
   logic       tx_q, tx_d;
   logic       en_rx_q, rx_q;
   logic       frame_start;
   logic [4:0] slot;

   assign frame_start = ~f0 & f0_q;

   // TX is decoded from next-state values so it lines up with cnt, no extra latency
   always_comb begin
      cnt_d    = frame_start ? 9'd0 : cnt_q + 9'd1;
      synced_d = synced_q | frame_start;
      sel_d    = frame_start ? select : sel_q;
      slot     = sel_d ? SLOT_B : SLOT_A;
      en_tx_d  = synced_d & (cnt_d[8:4] == slot);
      tx_d     = en_tx_d & ~cnt_d[0];
   end

   always_ff @(posedge c4) begin
      if (!rst_n) begin
         f0_q     <= 1'b1;
         cnt_q    <= '0;
         synced_q <= 1'b0;
         sel_q    <= 1'b0;
         en_tx_q  <= 1'b0;
         tx_q     <= 1'b0;
         en_rx_q  <= 1'b0;
         rx_q     <= 1'b0;
      end else begin
         f0_q     <= f0;
         cnt_q    <= cnt_d;
         synced_q <= synced_d;
         sel_q    <= sel_d;
         en_tx_q  <= en_tx_d;
         tx_q     <= tx_d;
         en_rx_q  <= en_tx_q;
         rx_q     <= tx_q;
      end
   end

   assign clk_en_tx = en_tx_q;
   assign clk_tx    = tx_q;
   assign clk_en_rx = en_rx_q;
   assign clk_rx    = rx_q;

endmodule

// File: tb/tb_tdm_converter.sv
// Directed bench for tdm_converter: two instances (slot 0 and slot 31 on select=0)
// share the timing inputs; expected window/clock values come from cnt and slot.
module tb_tdm_converter;

   logic c4 = 1'b0;
   logic rst_n, f0, select;
   logic en_tx0, en_rx0, tx0, rx0;
   logic en_tx1, en_rx1, tx1, rx1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 c4 = ~c4;

   tdm_converter #(.TS_A(0), .TS_B(16)) dut0 (
      .c4(c4), .rst_n(rst_n), .f0(f0), .select(select),
      .clk_en_tx(en_tx0), .clk_en_rx(en_rx0), .clk_tx(tx0), .clk_rx(rx0)
   );

   tdm_converter #(.TS_A(31), .TS_B(16)) dut1 (
      .c4(c4), .rst_n(rst_n), .f0(f0), .select(select),
      .clk_en_tx(en_tx1), .clk_en_rx(en_rx1), .clk_tx(tx1), .clk_rx(rx1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge c4);
      #1;
   endtask

   // {enable, clock} for a cycle at count c with active slot s; s<0 means unsynced
   function automatic logic [1:0] exp_out(input int s, input int c);
      logic en;
      en = (s >= 0) && ((c / 16) == s);
      return {en, en && ((c % 2) == 0)};
   endfunction

   task automatic frame_pulse();
      f0 = 1'b0;
      tick();
      f0 = 1'b1;
   endtask

   task automatic idle_zero(input string tag, input int n);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         acc = acc | en_tx0 | en_rx0 | tx0 | rx0 | en_tx1 | en_rx1 | tx1 | rx1;
      end
      chk(tag, {31'd0, acc}, 32'd0);
   endtask

   // Check cycles c=0..len-1 of a frame; ends sitting in cycle len-1.
   // p0/p1 and prevc describe the cycle preceding c=0 (for the RX delay).
   task automatic run_frame(input int s0, input int s1, input int p0, input int p1,
                            input int prevc, input int len, input int sel_at);
      for (int c = 0; c < len; c++) begin
         chk("tx0", {30'd0, en_tx0, tx0}, {30'd0, exp_out(s0, c)});
         chk("tx1", {30'd0, en_tx1, tx1}, {30'd0, exp_out(s1, c)});
         chk("rx0", {30'd0, en_rx0, rx0},
             {30'd0, (c == 0) ? exp_out(p0, prevc) : exp_out(s0, c - 1)});
         chk("rx1", {30'd0, en_rx1, rx1},
             {30'd0, (c == 0) ? exp_out(p1, prevc) : exp_out(s1, c - 1)});
         if (c == sel_at) select = 1'b1;
         if (c < len - 1) tick();
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      f0     = 1'b1;
      select = 1'b0;
      repeat (3) tick();
      chk("rst_en_tx", {31'd0, en_tx0}, 32'd0);
      chk("rst_tx",    {31'd0, tx0},    32'd0);
      chk("rst_en_rx", {31'd0, en_rx1}, 32'd0);
      chk("rst_rx",    {31'd0, rx1},    32'd0);
      rst_n = 1'b1;

      idle_zero("no_f0_idle", 600);

      // first frame; select flips mid-frame but slot 0 / 31 stay for this frame
      frame_pulse();
      chk("first_en_tx", {31'd0, en_tx0}, 32'd1);
      chk("first_tx",    {31'd0, tx0},    32'd1);
      run_frame(0, 31, -1, -1, 0, 512, 100);

      // select=1 now in effect: both instances use slot 16
      frame_pulse();
      chk("sel_b_c0", {31'd0, en_tx0}, 32'd0);
      run_frame(16, 16, 0, 31, 511, 512, -1);
      select = 1'b0;

      frame_pulse();
      run_frame(0, 31, 16, 16, 511, 512, -1);

      // slot 31 RX window spills into cnt=0 of the next frame
      frame_pulse();
      chk("s31_rx_wrap", {30'd0, en_rx1, rx1}, 32'd2);
      run_frame(0, 31, 0, 31, 511, 512, -1);

      // missing f0: counter free-runs, then an f0 three cycles early
      tick();
      run_frame(0, 31, 0, 31, 511, 509, -1);
      frame_pulse();
      chk("early_realign", {31'd0, en_tx0}, 32'd1);
      run_frame(0, 31, 0, 31, 508, 512, -1);

      // reset inside the slot-0 window at cnt=5
      frame_pulse();
      run_frame(0, 31, 0, 31, 511, 6, -1);
      rst_n = 1'b0;
      tick();
      chk("rst_cut_en_tx", {31'd0, en_tx0}, 32'd0);
      chk("rst_cut_tx",    {31'd0, tx0},    32'd0);
      chk("rst_cut_en_rx", {31'd0, en_rx0}, 32'd0);
      chk("rst_cut_rx",    {31'd0, rx0},    32'd0);
      rst_n = 1'b1;
      idle_zero("post_rst_idle", 600);

      frame_pulse();
      run_frame(0, 31, -1, -1, 0, 32, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
